// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, colour word type.
package vga_pkg;

  // Default 640x480@60 Hz timing (pixels / lines)
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Width of the pixel/line counters
  localparam int CNT_W = 10;

  // 3-3-2 colour word shared with the frame buffer and video mux
  localparam int RGB_W = 8;
  typedef logic [RGB_W-1:0] rgb_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Bus between the VGA timing generator and its consumers.
interface vga_sync_gen_if;
  logic                         en;
  logic [vga_pkg::CNT_W-1:0]    pixel_x;
  logic [vga_pkg::CNT_W-1:0]    pixel_y;
  logic                         frame_start;
  vga_pkg::rgb_t                rgb_in;
  logic                         hsync;
  logic                         vsync;
  logic                         video_on;
  vga_pkg::rgb_t                rgb_out;

  // Timing generator side
  modport master (
    input  en, rgb_in,
    output pixel_x, pixel_y, frame_start, hsync, vsync, video_on, rgb_out
  );

  // Frame buffer / connector side
  modport slave (
    output en, rgb_in,
    input  pixel_x, pixel_y, frame_start, hsync, vsync, video_on, rgb_out
  );
endinterface

// File: rtl/vga_delay_line.sv
// Enable-gated shift register, N bits wide and D stages deep, reset to R.
// D=0 degenerates to a straight wire.
module vga_delay_line #(
  parameter int             N = 1,
  parameter int             D = 1,
  parameter logic [N-1:0]   R = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  if (D == 0) begin : g_pass
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst, en};
    assign o_q      = i_d;
  end else begin : g_shift
    logic [N-1:0] r_sr [D];

    // Shift one stage per enabled tick; reset loads every stage with R
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < D; i++) r_sr[i] <= R;
      end else if (en) begin
        r_sr[0] <= i_d;
        for (int i = 1; i < D; i++) r_sr[i] <= r_sr[i-1];
      end
    end

    assign o_q = r_sr[D-1];
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters, sync/blank decode, and an
// alignment pipeline that matches the frame-buffer read latency.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY  = DEF_H_DISPLAY,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_DISPLAY  = DEF_V_DISPLAY,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int PIPE_DELAY = 1
) (
  input  logic            clk_in,
  input  logic            rst,
  vga_sync_gen_if.master  bus
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPLAY + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPLAY + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FP + V_SYNC);

  if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_pipe
    $error("vga_sync_gen: PIPE_DELAY must be within 0..4");
  end
  if (H_TOTAL >= 1024 || V_TOTAL >= 1024) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must be below 1024");
  end

  logic [CNT_W-1:0] r_pixel_x;
  logic [CNT_W-1:0] r_pixel_y;

  // Raster counters: x runs every enabled tick, y steps on each x wrap
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_pixel_x <= '0;
      r_pixel_y <= '0;
    end else if (bus.en) begin
      if (r_pixel_x == H_LAST) begin
        r_pixel_x <= '0;
        if (r_pixel_y == V_LAST) r_pixel_y <= '0;
        else                     r_pixel_y <= r_pixel_y + CNT_W'(1);
      end else begin
        r_pixel_x <= r_pixel_x + CNT_W'(1);
      end
    end
  end

  // ---- stage p0: raw decode straight from the counters ----
  logic       w_h_sync_raw_p0;
  logic       w_v_sync_raw_p0;
  logic       w_vis_raw_p0;
  logic [2:0] w_raw_p0;
  logic [2:0] w_dly_p1;

  assign w_h_sync_raw_p0 = !((r_pixel_x >= HS_START) && (r_pixel_x < HS_END));
  assign w_v_sync_raw_p0 = !((r_pixel_y >= VS_START) && (r_pixel_y < VS_END));
  assign w_vis_raw_p0    = (r_pixel_x < H_VIS) && (r_pixel_y < V_VIS);
  assign w_raw_p0        = {w_h_sync_raw_p0, w_v_sync_raw_p0, w_vis_raw_p0};

  // ---- stage p1: align with frame-buffer read latency ----
  vga_delay_line #(
    .N (3),
    .D (PIPE_DELAY),
    .R (3'b110)
  ) u_align (
    .clk (clk_in),
    .rst (rst),
    .en  (bus.en),
    .i_d (w_raw_p0),
    .o_q (w_dly_p1)
  );

  // ---- stage p2: pin registers ----
  logic r_hsync_p2;
  logic r_vsync_p2;
  logic r_video_on_p2;
  rgb_t r_rgb_p2;

  // Register the aligned flags and blank the colour outside the visible area
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_hsync_p2    <= 1'b1;
      r_vsync_p2    <= 1'b1;
      r_video_on_p2 <= 1'b0;
      r_rgb_p2      <= '0;
    end else if (bus.en) begin
      r_hsync_p2    <= w_dly_p1[2];
      r_vsync_p2    <= w_dly_p1[1];
      r_video_on_p2 <= w_dly_p1[0];
      r_rgb_p2      <= w_dly_p1[0] ? bus.rgb_in : '0;
    end
  end

  assign bus.pixel_x     = r_pixel_x;
  assign bus.pixel_y     = r_pixel_y;
  assign bus.frame_start = (r_pixel_x == '0) && (r_pixel_y == '0) && bus.en;
  assign bus.hsync       = r_hsync_p2;
  assign bus.vsync       = r_vsync_p2;
  assign bus.video_on    = r_video_on_p2;
  assign bus.rgb_out     = r_rgb_p2;

endmodule
